// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register map, fixed source
// indices and the width of the request id.
package intc_pkg;

  localparam int unsigned ICTR_A = 0;
  localparam int unsigned IEN_A  = 1;
  localparam int unsigned IPND_A = 2;
  localparam int unsigned ISRV_A = 3;
  localparam int unsigned IVEC_A = 4;
  localparam int unsigned EOI_A  = 5;

  localparam int unsigned SRC_T0 = 0;
  localparam int unsigned SRC_T1 = 1;

  localparam int unsigned IDW = 4;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set and the index of the
// lowest one (lower index = higher priority).
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0] vec_i,
  output logic            valid_o,
  output logic [IDW-1:0]  idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (vec_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/intc.sv
// Interrupt controller: edge-detects source pulses into pending bits, masks and
// prioritises them against the in-service set, and presents one registered request.
module intc
  import intc_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 13,
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   din,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  output logic [DW-1:0]   dout,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  input  logic            irq_ack
);

  logic            ictr_q, ictr_d;
  logic [NSRC-1:0] ien_q, ien_d;
  logic [NSRC-1:0] ipnd_q, ipnd_d;
  logic [NSRC-1:0] isrv_q, isrv_d;
  logic [NSRC-1:0] src_q;
  logic            req_q, req_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   dout_q, dout_d;

  logic [NSRC-1:0] evt, cand, ack_oh, eoi_oh, w1c_mask;
  logic            cand_vld, isrv_vld, req_cond, ack_ok;
  logic [IDW-1:0]  best_idx, isrv_idx;
  logic [IDW:0]    lim;
  logic            wr_ictr, wr_ien, wr_ipnd, wr_eoi;
  logic [DW-1:0]   rdata;

  assign wr_ictr = we && (addr == AW'(ICTR_A));
  assign wr_ien  = we && (addr == AW'(IEN_A));
  assign wr_ipnd = we && (addr == AW'(IPND_A));
  assign wr_eoi  = we && (addr == AW'(EOI_A));

  assign evt  = irq_src & ~src_q;
  assign cand = ipnd_q & ien_q;

  intc_prio_enc #(.NSRC(NSRC)) u_cand_enc (
    .vec_i   (cand),
    .valid_o (cand_vld),
    .idx_o   (best_idx)
  );

  intc_prio_enc #(.NSRC(NSRC)) u_isrv_enc (
    .vec_i   (isrv_q),
    .valid_o (isrv_vld),
    .idx_o   (isrv_idx)
  );

  // With nothing in service every source is allowed to preempt.
  assign lim      = isrv_vld ? {1'b0, isrv_idx} : (IDW + 1)'(NSRC);
  assign req_cond = ictr_q && cand_vld && ({1'b0, best_idx} < lim);
  assign ack_ok   = irq_ack && req_q;

  always_comb begin
    ack_oh = '0;
    eoi_oh = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      ack_oh[i] = ack_ok && (id_q == IDW'(i));
      eoi_oh[i] = wr_eoi && isrv_vld && (isrv_idx == IDW'(i));
    end
  end

  assign w1c_mask = wr_ipnd ? din[NSRC-1:0] : '0;

  always_comb begin
    ictr_d = wr_ictr ? din[0] : ictr_q;
    ien_d  = wr_ien ? din[NSRC-1:0] : ien_q;
    // New events are OR-ed last so a same-edge set beats W1C or ack.
    ipnd_d = (ipnd_q & ~w1c_mask & ~ack_oh) | evt;
    // EOI acts on the pre-ack set; the ack then marks its own bit.
    isrv_d = (isrv_q & ~eoi_oh) | ack_oh;
    req_d  = ack_ok ? 1'b0 : req_cond;
    id_d   = (!ack_ok && req_cond) ? best_idx : id_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      AW'(ICTR_A): rdata[0] = ictr_q;
      AW'(IEN_A):  rdata[NSRC-1:0] = ien_q;
      AW'(IPND_A): rdata[NSRC-1:0] = ipnd_q;
      AW'(ISRV_A): rdata[NSRC-1:0] = isrv_q;
      AW'(IVEC_A): begin
        rdata[DW-1]    = req_q;
        rdata[IDW-1:0] = id_q;
      end
      default: rdata = '0;
    endcase
    dout_d = we ? dout_q : rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ictr_q <= 1'b0;
      ien_q  <= '0;
      ipnd_q <= '0;
      isrv_q <= '0;
      src_q  <= '0;
      req_q  <= 1'b0;
      id_q   <= '0;
      dout_q <= '0;
    end else begin
      ictr_q <= ictr_d;
      ien_q  <= ien_d;
      ipnd_q <= ipnd_d;
      isrv_q <= isrv_d;
      src_q  <= irq_src;
      req_q  <= req_d;
      id_q   <= id_d;
      dout_q <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign irq_req = req_q;
  assign irq_id  = id_q;

  if (NSRC < DW) begin : g_din_hi
    logic unused_din;
    assign unused_din = ^din[DW-1:NSRC];
  end

endmodule
